timer_array: RTL and testbench

//  Multi-channel successor of the single one-shot Avalon-MM countdown timer.
//  N_CHANNELS independent down-counters share one programmable prescaler.

---
 rtl/timer_array.sv | 213 +++++++++++++++++++++
 tb/tb_timer_array.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_array.sv
`default_nettype none
// ============================================================================
// Module   : timer_array
// Brief    : N independent countdown timers behind Avalon-MM, with a shared
//            prescaler and a masked sticky-status interrupt
// Revision : 1.0
// ============================================================================
module timer_array #(
  parameter int N_CHANNELS  = 4,
  parameter int CNT_WIDTH   = 64,
  parameter int PRESC_WIDTH = 16,
  localparam int ADDR_W     = $clog2(8*(N_CHANNELS+1))
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avmms_address,
  input  logic              avmms_write,
  input  logic [31:0]       avmms_writedata,
  input  logic [3:0]        avmms_byteenable,
  input  logic              avmms_read,
  output logic [31:0]       avmms_readdata,
  output logic              coe_interrupt
);

  localparam int          PAGE_W = ADDR_W - 3;
  localparam logic [31:0] C_INFO = {8'h00, 8'(CNT_WIDTH), 8'h00, 8'(N_CHANNELS)};

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    return (old_v & ~m) | (wd & m);
  endfunction

  logic [PAGE_W-1:0]            w_page;
  logic [2:0]                   w_off;
  logic                         w_glb;
  logic [N_CHANNELS-1:0]        w_ch_hit;
  logic [N_CHANNELS-1:0]        w_expire;
  logic [N_CHANNELS-1:0]        w_busy;
  logic [N_CHANNELS-1:0]        w_periodic;
  logic [N_CHANNELS-1:0][63:0]  w_load_q;
  logic [N_CHANNELS-1:0][63:0]  w_count_q;
  logic [N_CHANNELS-1:0][31:0]  w_shadow_q;
  logic [31:0]                  w_bemask;
  logic [31:0]                  w_clr;
  logic [31:0]                  w_en_new;
  logic [31:0]                  w_presc_new;
  logic [31:0]                  w_rdata;
  logic                         w_tick;
  logic                         w_wr_presc;

  logic [N_CHANNELS-1:0]        r_status;
  logic [N_CHANNELS-1:0]        r_enable;
  logic [PRESC_WIDTH-1:0]       r_prescale;
  logic [PRESC_WIDTH-1:0]       r_presc_cnt;
  logic [31:0]                  r_rdata;

  assign w_page     = avmms_address[ADDR_W-1:3];
  assign w_off      = avmms_address[2:0];
  assign w_glb      = (w_page == '0);
  assign w_tick     = (r_presc_cnt == r_prescale);
  assign w_wr_presc = avmms_write & w_glb & (w_off == 3'd2);

  always_comb begin
    for (int b = 0; b < 4; b++) w_bemask[b*8 +: 8] = avmms_byteenable[b] ? 8'hFF : 8'h00;
  end

  assign w_clr       = (avmms_write && w_glb && w_off == 3'd0) ? (avmms_writedata & w_bemask) : 32'h0;
  assign w_en_new    = f_merge(32'(r_enable), avmms_writedata, avmms_byteenable);
  assign w_presc_new = f_merge(32'(r_prescale), avmms_writedata, avmms_byteenable);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_status    <= '0;
      r_enable    <= '0;
      r_prescale  <= '0;
      r_presc_cnt <= '0;
    end else begin
      // A fresh expiry outranks a clear landing on the same edge
      r_status <= (r_status & ~N_CHANNELS'(w_clr)) | w_expire;
      if (avmms_write && w_glb && w_off == 3'd1) r_enable <= N_CHANNELS'(w_en_new);
      if (w_wr_presc) begin
        r_prescale  <= PRESC_WIDTH'(w_presc_new);
        r_presc_cnt <= '0;
      end else if (w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
    localparam logic [PAGE_W-1:0] C_PAGE = PAGE_W'(i + 1);

    logic [CNT_WIDTH-1:0] r_load;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_busy;
    logic                 r_periodic;
    logic [31:0]          r_shadow;
    logic [63:0]          w_ld64;
    logic [63:0]          w_cnt64;
    logic [63:0]          w_ld_new;
    logic                 w_wr_ctrl;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_load_nz;
    logic                 w_cnt_one;

    assign w_ch_hit[i] = (w_page == C_PAGE);
    assign w_wr_ctrl   = avmms_write & w_ch_hit[i] & (w_off == 3'd0) & avmms_byteenable[0];
    assign w_start     = w_wr_ctrl & avmms_writedata[0];
    assign w_stop      = w_wr_ctrl & avmms_writedata[1];
    assign w_load_nz   = (r_load != '0);
    assign w_cnt_one   = (r_count == CNT_WIDTH'(1));

    always_comb begin
      w_ld64                  = '0;
      w_ld64[CNT_WIDTH-1:0]   = r_load;
      w_cnt64                 = '0;
      w_cnt64[CNT_WIDTH-1:0]  = r_count;
    end

    always_comb begin
      w_ld_new = w_ld64;
      if (avmms_write && w_ch_hit[i] && w_off == 3'd1)
        w_ld_new[31:0] = f_merge(w_ld64[31:0], avmms_writedata, avmms_byteenable);
      else if (avmms_write && w_ch_hit[i] && w_off == 3'd2)
        w_ld_new[63:32] = f_merge(w_ld64[63:32], avmms_writedata, avmms_byteenable);
    end

    assign w_expire[i]   = w_tick & r_busy & w_cnt_one & ~(w_start & w_load_nz) & ~w_stop;
    assign w_busy[i]     = r_busy;
    assign w_periodic[i] = r_periodic;
    assign w_load_q[i]   = w_ld64;
    assign w_count_q[i]  = w_cnt64;
    assign w_shadow_q[i] = r_shadow;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_load     <= '0;
        r_count    <= '0;
        r_busy     <= 1'b0;
        r_periodic <= 1'b0;
        r_shadow   <= '0;
      end else begin
        r_load <= CNT_WIDTH'(w_ld_new);
        if (w_wr_ctrl) r_periodic <= avmms_writedata[2];
        if (avmms_read && w_ch_hit[i] && w_off == 3'd3) r_shadow <= w_cnt64[63:32];

        if (w_start && w_load_nz) begin
          r_count <= r_load;
          r_busy  <= 1'b1;
        end else if (w_stop) begin
          r_count <= '0;
          r_busy  <= 1'b0;
        end else if (w_tick && r_busy) begin
          if (w_cnt_one) begin
            // Reload picks up whatever LOAD holds now, including a late write
            if (r_periodic && w_load_nz) begin
              r_count <= r_load;
            end else begin
              r_count <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_count <= r_count - CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    if (w_glb) begin
      case (w_off)
        3'd0:    w_rdata = 32'(r_status);
        3'd1:    w_rdata = 32'(r_enable);
        3'd2:    w_rdata = 32'(r_prescale);
        3'd3:    w_rdata = C_INFO;
        default: w_rdata = 32'h0;
      endcase
    end
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (w_ch_hit[i]) begin
        case (w_off)
          3'd0:    w_rdata = {28'h0, w_busy[i], w_periodic[i], 2'b00};
          3'd1:    w_rdata = w_load_q[i][31:0];
          3'd2:    w_rdata = w_load_q[i][63:32];
          3'd3:    w_rdata = w_count_q[i][31:0];
          3'd4:    w_rdata = w_shadow_q[i];
          default: w_rdata = 32'h0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (avmms_read) begin
      r_rdata <= w_rdata;
    end
  end

  assign avmms_readdata = r_rdata;
  assign coe_interrupt  = |(r_status & r_enable);

endmodule
`default_nettype wire

// File: tb/tb_timer_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_array
// Brief    : Self-checking bench for timer_array: vector table, directed
//            timing sequences and randomized traffic against a reference model
// Revision : 1.0
// ============================================================================
module tb_timer_array;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  avmms_address;
  logic        avmms_write;
  logic [31:0] avmms_writedata;
  logic [3:0]  avmms_byteenable;
  logic        avmms_read;
  logic [31:0] avmms_readdata;
  logic        coe_interrupt;

  int checks = 0;
  int errors = 0;

  timer_array #(.N_CHANNELS(4), .CNT_WIDTH(64), .PRESC_WIDTH(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avmms_address    (avmms_address),
    .avmms_write      (avmms_write),
    .avmms_writedata  (avmms_writedata),
    .avmms_byteenable (avmms_byteenable),
    .avmms_read       (avmms_read),
    .avmms_readdata   (avmms_readdata),
    .coe_interrupt    (coe_interrupt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] m_load   [NCH];
  logic [63:0] m_count  [NCH];
  logic [31:0] m_shadow [NCH];
  bit          m_busy   [NCH];
  bit          m_per    [NCH];
  logic [3:0]  m_status, m_en;
  int unsigned m_presc, m_pcnt;
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_load[c] = 0; m_count[c] = 0; m_shadow[c] = 0; m_busy[c] = 0; m_per[c] = 0;
    end
    m_status = 0; m_en = 0; m_presc = 0; m_pcnt = 0; m_rdata = 0;
  endtask

  function automatic logic [31:0] m_read(input int a);
    int pg, off, c;
    pg = a / 8; off = a % 8;
    if (pg == 0) begin
      case (off)
        0: return {28'h0, m_status};
        1: return {28'h0, m_en};
        2: return m_presc;
        3: return 32'h0040_0004;
        default: return 0;
      endcase
    end else if (pg <= NCH) begin
      c = pg - 1;
      case (off)
        0: return {28'h0, m_busy[c], m_per[c], 2'b00};
        1: return m_load[c][31:0];
        2: return m_load[c][63:32];
        3: return m_count[c][31:0];
        4: return m_shadow[c];
        default: return 0;
      endcase
    end
    return 0;
  endfunction

  task automatic model_step(input bit wr, input bit rd, input int a,
                            input logic [31:0] wd, input logic [3:0] be);
    bit tick, ctrl, st, sp;
    int pg, off;
    logic [31:0] bm, clr;
    logic [3:0] set;
    tick = (m_pcnt == m_presc);
    pg = a / 8; off = a % 8;
    for (int b = 0; b < 4; b++) bm[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    if (rd) begin
      m_rdata = m_read(a);
      if (pg >= 1 && pg <= NCH && off == 3) m_shadow[pg-1] = m_count[pg-1][63:32];
    end
    set = 0;
    for (int c = 0; c < NCH; c++) begin
      ctrl = wr && (pg == c + 1) && (off == 0) && be[0];
      st = ctrl && wd[0];
      sp = ctrl && wd[1];
      if (st && m_load[c] != 0) begin
        m_count[c] = m_load[c]; m_busy[c] = 1;
      end else if (sp) begin
        m_count[c] = 0; m_busy[c] = 0;
      end else if (tick && m_busy[c]) begin
        if (m_count[c] == 1) begin
          set[c] = 1'b1;
          if (m_per[c] && m_load[c] != 0) m_count[c] = m_load[c];
          else begin m_count[c] = 0; m_busy[c] = 0; end
        end else begin
          m_count[c] = m_count[c] - 1;
        end
      end
      if (ctrl) m_per[c] = wd[2];
      if (wr && pg == c + 1 && off == 1) m_load[c][31:0]  = (m_load[c][31:0]  & ~bm) | (wd & bm);
      if (wr && pg == c + 1 && off == 2) m_load[c][63:32] = (m_load[c][63:32] & ~bm) | (wd & bm);
    end
    clr = (wr && a == 0) ? (wd & bm) : 32'h0;
    m_status = (m_status & ~clr[3:0]) | set;
    if (wr && a == 1) m_en = (m_en & ~bm[3:0]) | (wd[3:0] & bm[3:0]);
    if (wr && a == 2) begin
      m_presc = ((m_presc & ~bm) | (wd & bm)) & 32'h0000_FFFF;
      m_pcnt  = 0;
    end else begin
      m_pcnt = tick ? 0 : m_pcnt + 1;
    end
  endtask

  // One bus cycle; every cycle compares the interrupt, reads compare readdata
  task automatic do_cycle(input bit wr, input bit rd, input int a,
                          input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    avmms_write      = wr;
    avmms_read       = rd;
    avmms_address    = 6'(a);
    avmms_writedata  = wd;
    avmms_byteenable = be;
    @(posedge clk);
    model_step(wr, rd, a, wd, be);
    #1;
    check("model_irq", {31'h0, coe_interrupt}, {31'h0, |(m_status & m_en)});
    if (rd) check("model_rdata", avmms_readdata, m_rdata);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    do_cycle(1'b1, 1'b0, a, d, 4'hF);
  endtask

  task automatic rd(input int a);
    do_cycle(1'b0, 1'b1, a, 32'h0, 4'h0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  typedef struct {
    string       name;
    bit          w;
    bit          r;
    int          a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"info",       0, 1, 3,  32'h0,         4'h0, 32'h0040_0004, 0};
    vecs[1]  = '{"status_rst", 0, 1, 0,  32'h0,         4'h0, 32'h0,         0};
    vecs[2]  = '{"resv4",      0, 1, 5,  32'h0,         4'h0, 32'h0,         0};
    vecs[3]  = '{"en_wr",      1, 0, 1,  32'hFFFF_FFFF, 4'hF, 32'h0,         0};
    vecs[4]  = '{"en_rd",      0, 1, 1,  32'h0,         4'h0, 32'h0000_000F, 0};
    vecs[5]  = '{"presc_wr",   1, 0, 2,  32'h1234_5678, 4'h3, 32'h0,         0};
    vecs[6]  = '{"presc_rd",   0, 1, 2,  32'h0,         4'h0, 32'h0000_5678, 0};
    vecs[7]  = '{"presc_clr",  1, 0, 2,  32'h0,         4'hF, 32'h0,         0};
    vecs[8]  = '{"ld_lo_be",   1, 0, 33, 32'hDEAD_BEEF, 4'h5, 32'h0,         0};
    vecs[9]  = '{"ld_lo_rd",   0, 1, 33, 32'h0,         4'h0, 32'h00AD_00EF, 0};
    vecs[10] = '{"ld_hi_wr",   1, 0, 34, 32'hCAFE_F00D, 4'hF, 32'h0,         0};
    vecs[11] = '{"ld_hi_rd",   0, 1, 34, 32'h0,         4'h0, 32'hCAFE_F00D, 0};
    vecs[12] = '{"per_wr",     1, 0, 8,  32'h4,         4'h1, 32'h0,         0};
    vecs[13] = '{"per_rd",     0, 1, 8,  32'h0,         4'h0, 32'h0000_0004, 0};
    vecs[14] = '{"per_clr",    1, 0, 8,  32'h0,         4'h1, 32'h0,         0};
    vecs[15] = '{"resv_ch",    0, 1, 13, 32'h0,         4'h0, 32'h0,         0};

    reset_n = 1'b0;
    avmms_write = 0; avmms_read = 0; avmms_address = 0;
    avmms_writedata = 0; avmms_byteenable = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", avmms_readdata, 32'h0);
    check("rst_irq", {31'h0, coe_interrupt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      do_cycle(vecs[v].w, vecs[v].r, vecs[v].a, vecs[v].wd, vecs[v].be);
      if (vecs[v].r) check(vecs[v].name, avmms_readdata, vecs[v].exp_rd);
      check({vecs[v].name, "_irq"}, {31'h0, coe_interrupt}, {31'h0, vecs[v].exp_irq});
    end

    // One-shot, PRESCALE=0: expiry 5 clocks after START
    wr(2, 0); wr(9, 5); wr(10, 0); wr(1, 1); wr(8, 1);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      check("t1_irq", {31'h0, coe_interrupt}, (k == 5) ? 32'h1 : 32'h0);
    end
    rd(8);  check("t1_ctrl", avmms_readdata, 32'h0);
    rd(11); check("t1_count", avmms_readdata, 32'h0);
    wr(0, 32'hF);

    // Periodic, PRESCALE=3, LOAD=2: START lands 4 edges after the PRESCALE write
    wr(2, 3); wr(17, 2); wr(18, 0); wr(1, 2); wr(16, 5);
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) wr(0, 2); else idle(1);
      check("t2_irq", {31'h0, coe_interrupt}, (k == 8 || k == 16) ? 32'h1 : 32'h0);
    end
    wr(16, 2); wr(0, 32'hF);

    // STOP mid-count and START with LOAD=0
    wr(2, 0); wr(25, 10); wr(26, 0); wr(1, 4); wr(24, 1);
    idle(7);
    wr(24, 2);
    idle(15);
    rd(0);  check("t3_status", avmms_readdata, 32'h0);
    rd(27); check("t3_count", avmms_readdata, 32'h0);
    rd(24); check("t3_ctrl", avmms_readdata, 32'h0);
    wr(25, 0); wr(24, 1);
    rd(24); check("t3_zero_start", avmms_readdata, 32'h0);

    // 64-bit count across the 32-bit boundary, with shadowed high word
    wr(33, 2); wr(34, 1); wr(2, 7); wr(32, 1);
    idle(7);
    rd(35); check("t4_lo1", avmms_readdata, 32'h1);
    rd(36); check("t4_hi1", avmms_readdata, 32'h1);
    idle(14);
    rd(35); check("t4_lo2", avmms_readdata, 32'hFFFF_FFFF);
    rd(36); check("t4_hi2", avmms_readdata, 32'h0);
    wr(32, 2); wr(2, 0);

    // Expiry and W1C on the same edge; masked status stays visible
    wr(1, 1); wr(9, 5); wr(8, 1);
    idle(4);
    do_cycle(1'b1, 1'b0, 0, 32'h1, 4'h1);
    check("t5_irq_set_wins", {31'h0, coe_interrupt}, 32'h1);
    rd(0); check("t5_status", avmms_readdata, 32'h1);
    wr(1, 0);
    check("t5_masked_irq", {31'h0, coe_interrupt}, 32'h0);
    rd(0); check("t5_masked_status", avmms_readdata, 32'h1);
    wr(0, 32'hF);

    // Asynchronous reset with every channel busy
    wr(9, 2); wr(17, 100); wr(25, 100); wr(33, 100); wr(34, 0); wr(1, 32'hF);
    wr(8, 1); wr(16, 1); wr(24, 1); wr(32, 1);
    idle(2);
    rd(3); check("t6_pre_info", avmms_readdata, 32'h0040_0004);
    check("t6_pre_irq", {31'h0, coe_interrupt}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_rdata", avmms_readdata, 32'h0);
    check("t6_rst_irq", {31'h0, coe_interrupt}, 32'h0);
    model_reset();
    avmms_read = 0; avmms_write = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(30);
    check("t6_post_irq", {31'h0, coe_interrupt}, 32'h0);
    rd(3);  check("t6_info", avmms_readdata, 32'h0040_0004);
    rd(16); check("t6_ctrl1", avmms_readdata, 32'h0);
    rd(0);  check("t6_status", avmms_readdata, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int unsigned r, ch;
      r  = $urandom_range(0, 9);
      ch = $urandom_range(1, NCH);
      case (r)
        0, 1, 2: rd(int'($urandom_range(0, 63)));
        3: do_cycle(1'b1, 1'b0, int'(ch * 8), 32'($urandom_range(0, 7)),
                    {3'b000, ($urandom_range(0, 7) != 0)});
        4: wr(int'(ch * 8 + 1), 32'($urandom_range(0, 6)));
        5: do_cycle(1'b1, 1'b0, 0, $urandom, 4'($urandom_range(0, 15)));
        6: do_cycle(1'b1, 1'b0, 1, $urandom, 4'($urandom_range(0, 15)));
        7: if ($urandom_range(0, 3) == 0) wr(2, 32'($urandom_range(0, 3))); else idle(1);
        default: idle(1);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
